// File: rtl/dcache_controller_if.sv
// CPU-side load/store port of the data cache controller.
// Signal names keep the cache's point of view: *_i are driven by the CPU,
// *_o are driven by the cache.
interface dcache_controller_if;
  logic [31:0] p1_addr_i;
  logic [31:0] p1_data_i;
  logic        p1_MemRead_i;
  logic        p1_MemWrite_i;
  logic [31:0] p1_data_o;
  logic        p1_stall_o;

  modport master (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
    input  p1_data_o, p1_stall_o
  );

  modport slave (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
    output p1_data_o, p1_stall_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Tag and data SRAMs are external; reads from them are combinational.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | serve hits in the same cycle, detect a miss
// MISS        | one cycle to inspect the victim's valid/dirty bits
// WRITEBACK   | write the dirty victim line to memory, wait for ack
// ALLOCATE    | fetch the requested line, fill SRAMs on the ack cycle
// REFILL_DONE | one stall cycle before the retried access hits in IDLE
module dcache_controller #(
  parameter int TAG_W = 22,
  parameter int IDX_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dcache_controller_if.slave   p1,
  output logic [IDX_W-1:0]     tag_addr_o,
  output logic [TAG_W+1:0]     tag_data_o,
  output logic                 tag_enable_o,
  output logic                 tag_write_o,
  input  logic [TAG_W+1:0]     tag_data_i,
  output logic [IDX_W-1:0]     data_addr_o,
  output logic [255:0]         data_data_o,
  output logic                 data_enable_o,
  output logic                 data_write_o,
  input  logic [255:0]         data_data_i,
  output logic [31:0]          mem_addr_o,
  output logic [255:0]         mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [255:0]         mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int OFF_W = 32 - TAG_W - IDX_W;

  typedef enum logic [2:0] {
    IDLE, MISS, WRITEBACK, ALLOCATE, REFILL_DONE
  } state_t;

  state_t             state;
  state_t             cur;
  logic               req;
  logic               wr;
  logic [IDX_W-1:0]   index;
  logic [2:0]         word;
  logic [TAG_W-1:0]   addr_tag;
  logic               hit;
  logic [255:0]       merged;
  logic               unused_ok;

  assign req       = p1.p1_MemRead_i | p1.p1_MemWrite_i;
  assign wr        = p1.p1_MemWrite_i;
  assign index     = p1.p1_addr_i[OFF_W +: IDX_W];
  assign word      = p1.p1_addr_i[4:2];
  assign addr_tag  = p1.p1_addr_i[31 -: TAG_W];
  assign hit       = tag_data_i[TAG_W+1] & (tag_data_i[TAG_W-1:0] == addr_tag);
  assign unused_ok = ^p1.p1_addr_i[1:0];

  // While reset is held the outputs behave as in IDLE, whatever the register holds.
  assign cur = rst_i ? state : IDLE;

  // Cached line with the addressed word replaced by the store data.
  always_comb begin
    merged = data_data_i;
    merged[{word, 5'b0} +: 32] = p1.p1_data_i;
  end

  // Next-state register; a started miss runs to completion even if req drops.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:        if (req && !hit) state <= MISS;
        MISS:        state <= (tag_data_i[TAG_W+1:TAG_W] == 2'b11) ? WRITEBACK : ALLOCATE;
        WRITEBACK:   if (mem_ack_i) state <= ALLOCATE;
        ALLOCATE:    if (mem_ack_i) state <= REFILL_DONE;
        REFILL_DONE: state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from state and the live request so hits complete in one cycle.
  always_comb begin
    tag_addr_o    = index;
    data_addr_o   = index;
    tag_enable_o  = req | (cur != IDLE);
    data_enable_o = req | (cur != IDLE);
    tag_data_o    = '0;
    tag_write_o   = 1'b0;
    data_data_o   = '0;
    data_write_o  = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    p1.p1_data_o  = '0;
    p1.p1_stall_o = 1'b0;
    case (cur)
      IDLE: begin
        if (req && hit) begin
          if (wr) begin
            data_write_o = 1'b1;
            data_data_o  = merged;
            tag_write_o  = 1'b1;
            tag_data_o   = {2'b11, addr_tag};
          end else begin
            p1.p1_data_o = data_data_i[{word, 5'b0} +: 32];
          end
        end else if (req) begin
          p1.p1_stall_o = 1'b1;
        end
      end
      MISS, REFILL_DONE: p1.p1_stall_o = 1'b1;
      WRITEBACK: begin
        p1.p1_stall_o = 1'b1;
        mem_enable_o  = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = {tag_data_i[TAG_W-1:0], index, {OFF_W{1'b0}}};
        mem_data_o    = data_data_i;
      end
      ALLOCATE: begin
        p1.p1_stall_o = 1'b1;
        mem_enable_o  = 1'b1;
        mem_addr_o    = {p1.p1_addr_i[31:OFF_W], {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          data_write_o = 1'b1;
          data_data_o  = mem_data_i;
          tag_write_o  = 1'b1;
          tag_data_o   = {2'b10, addr_tag};
        end
      end
      default: ;
    endcase
    if (!rst_i) begin
      tag_write_o  = 1'b0;
      data_write_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: tag/data SRAM models, a latency-configurable
// backing memory, a flat golden memory image checked every cycle, and
// directed scenarios with hand-computed expectations.
module tb_dcache_controller;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  dcache_controller_if p1 ();

  logic [4:0]   tag_addr_o, data_addr_o;
  logic [23:0]  tag_data_o, tag_data_i;
  logic         tag_enable_o, tag_write_o, data_enable_o, data_write_o;
  logic [255:0] data_data_o, data_data_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;

  dcache_controller #(.TAG_W(22), .IDX_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .p1(p1.slave),
    .tag_addr_o(tag_addr_o), .tag_data_o(tag_data_o), .tag_enable_o(tag_enable_o),
    .tag_write_o(tag_write_o), .tag_data_i(tag_data_i),
    .data_addr_o(data_addr_o), .data_data_o(data_data_o), .data_enable_o(data_enable_o),
    .data_write_o(data_write_o), .data_data_i(data_data_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_word(logic [29:0] wa);
    return {wa, 2'b00} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [255:0] init_line(logic [26:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({la, w[2:0]});
    return l;
  endfunction

  // ---------------- SRAM models ----------------
  logic [23:0]  tag_mem  [32];
  logic [255:0] data_mem [32];
  logic         sram_clr = 1'b1;
  logic         pl_en = 1'b0;
  logic [4:0]   pl_idx = '0;
  logic [23:0]  pl_tag = '0;
  logic [255:0] pl_line = '0;

  assign tag_data_i  = tag_mem[tag_addr_o];
  assign data_data_i = data_enable_o ? data_mem[data_addr_o] : '0;

  always @(posedge clk_i) begin
    if (sram_clr) begin
      for (int i = 0; i < 32; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else if (pl_en) begin
      tag_mem[pl_idx]  <= pl_tag;
      data_mem[pl_idx] <= pl_line;
    end else begin
      if (tag_enable_o && tag_write_o)   tag_mem[tag_addr_o]   <= tag_data_o;
      if (data_enable_o && data_write_o) data_mem[data_addr_o] <= data_data_o;
    end
  end

  // ---------------- backing memory ----------------
  logic [255:0] backing [logic [26:0]];
  int   mem_lat   = 10;
  logic ack_en    = 1'b1;
  logic stray_ack = 1'b0;
  int   cnt       = 0;

  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (pl_en && !pl_tag[22]) backing[{pl_tag[21:0], pl_idx}] = pl_line;
      if (mem_ack_i) begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        cnt        = 0;
      end else if (stray_ack) begin
        mem_ack_i  = 1'b1;
        mem_data_i = '1;
      end else if (mem_enable_o && ack_en) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) backing[mem_addr_o[31:5]] = mem_data_o;
          else mem_data_i = backing.exists(mem_addr_o[31:5]) ? backing[mem_addr_o[31:5]]
                                                             : init_line(mem_addr_o[31:5]);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- golden CPU-visible memory ----------------
  logic [31:0] gold [logic [29:0]];
  logic        chk_en = 1'b0;

  function automatic logic [31:0] gold_word(logic [29:0] wa);
    return gold.exists(wa) ? gold[wa] : init_word(wa);
  endfunction

  function automatic logic [255:0] gold_line(logic [26:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_word({la, w[2:0]});
    return l;
  endfunction

  function automatic void model_check();
    logic [31:0]  a      = p1.p1_addr_i;
    logic [4:0]   idx    = a[9:5];
    int           w      = int'(a[4:2]);
    logic         req    = p1.p1_MemRead_i | p1.p1_MemWrite_i;
    logic         wr     = p1.p1_MemWrite_i;
    logic [23:0]  t      = tag_mem[idx];
    logic         hit_m  = t[23] && (t[21:0] == a[31:10]);
    logic         wr_hit = req && wr && !p1.p1_stall_o;
    logic         fill   = mem_enable_o && !mem_write_o && mem_ack_i;
    logic [255:0] e;
    chk("m_tag_addr", tag_addr_o, idx);
    chk("m_data_addr", data_addr_o, idx);
    if (req) chk("m_enable", {tag_enable_o, data_enable_o}, 2'b11);
    if (req && !hit_m) chk("m_miss_stall", p1.p1_stall_o, 1'b1);
    if (req && !p1.p1_stall_o) chk("m_nostall_is_hit", hit_m, 1'b1);
    if (req && !wr && !p1.p1_stall_o) chk("m_load_data", p1.p1_data_o, gold_word(a[31:2]));
    else chk("m_load_zero", p1.p1_data_o, 32'h0);
    chk("m_data_write", data_write_o, wr_hit || fill);
    chk("m_tag_write", tag_write_o, wr_hit || fill);
    if (wr_hit) begin
      e = data_mem[idx];
      e[w*32 +: 32] = p1.p1_data_i;
      chk("m_store_line", data_data_o, e);
      chk("m_store_tag", tag_data_o, {2'b11, a[31:10]});
    end
    if (fill) begin
      chk("m_fill_line", data_data_o, mem_data_i);
      chk("m_fill_tag", tag_data_o, {2'b10, a[31:10]});
    end
    if (!mem_enable_o) begin
      chk("m_mem_idle", {mem_write_o, mem_addr_o, mem_data_o}, '0);
    end else if (mem_write_o) begin
      chk("m_wb_addr", mem_addr_o, {t[21:0], idx, 5'b0});
      chk("m_wb_data", mem_data_o, gold_line(mem_addr_o[31:5]));
    end else begin
      chk("m_fetch_addr", mem_addr_o, {a[31:5], 5'b0});
    end
    if (wr_hit) gold[a[31:2]] = p1.p1_data_i;
  endfunction

  initial begin
    forever begin
      @(negedge clk_i);
      if (pl_en)
        for (int w = 0; w < 8; w++) gold[{pl_tag[21:0], pl_idx, w[2:0]}] = pl_line[w*32 +: 32];
      if (rst_i && chk_en) model_check();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    p1.p1_MemRead_i  = rd;
    p1.p1_MemWrite_i = wr;
    p1.p1_addr_i     = a;
    p1.p1_data_i     = d;
  endtask

  task automatic preload(input logic [4:0] idx, input logic [23:0] tg, input logic [255:0] ln);
    pl_idx  = idx;
    pl_tag  = tg;
    pl_line = ln;
    pl_en   = 1'b1;
    cyc();
    pl_en   = 1'b0;
  endtask

  logic [255:0] line3, exp_line;
  int           n_alloc, g;

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    neg();
    chk("rst_mem_enable", mem_enable_o, 1'b0);
    chk("rst_writes", {tag_write_o, data_write_o, mem_write_o}, 3'b000);
    chk("rst_stall", p1.p1_stall_o, 1'b0);
    cyc();
    cyc();
    sram_clr = 1'b0;
    rst_i    = 1'b1;
    chk_en   = 1'b1;

    // Line 3, tag 1, clean. Address 0x46C selects word 3 (bits [4:2] = 3).
    for (int w = 0; w < 8; w++) line3[w*32 +: 32] = 32'h3000_0000 + w;
    line3[3*32 +: 32] = 32'hDEAD_BEEF;
    preload(5'd3, 24'h800001, line3);

    drive(1'b1, 1'b0, 32'h0000_046C, 32'h0);
    neg();
    chk("rd_hit_stall", p1.p1_stall_o, 1'b0);
    chk("rd_hit_data", p1.p1_data_o, 32'hDEAD_BEEF);
    chk("rd_hit_no_write", data_write_o, 1'b0);

    cyc();
    drive(1'b0, 1'b1, 32'h0000_0460, 32'h1234_5678);
    neg();
    exp_line = line3;
    exp_line[31:0] = 32'h1234_5678;
    chk("wr_hit_dwrite", data_write_o, 1'b1);
    chk("wr_hit_line", data_data_o, exp_line);
    chk("wr_hit_twrite", tag_write_o, 1'b1);
    chk("wr_hit_tag", tag_data_o, 24'hC00001);
    chk("wr_hit_stall", p1.p1_stall_o, 1'b0);

    cyc();
    drive(1'b1, 1'b0, 32'h0000_0460, 32'h0);
    neg();
    chk("rd_after_wr", p1.p1_data_o, 32'h1234_5678);

    cyc();
    drive(1'b1, 1'b1, 32'h0000_0464, 32'hCAFE_F00D);
    neg();
    chk("rdwr_is_write", data_write_o, 1'b1);
    chk("rdwr_no_load", p1.p1_data_o, 32'h0);
    chk("rdwr_stall", p1.p1_stall_o, 1'b0);

    // Clean miss on line 0 (invalid), latency 10.
    cyc();
    drive(1'b1, 1'b0, 32'h0000_0800, 32'h0);
    neg();
    chk("cm_idle_stall", p1.p1_stall_o, 1'b1);
    chk("cm_idle_mem", mem_enable_o, 1'b0);
    cyc();
    neg();
    chk("cm_miss_stall", p1.p1_stall_o, 1'b1);
    chk("cm_miss_mem", mem_enable_o, 1'b0);
    cyc();
    neg();
    chk("cm_alloc_en", {mem_enable_o, mem_write_o}, 2'b10);
    chk("cm_alloc_addr", mem_addr_o, 32'h0000_0800);
    n_alloc = 1;
    g = 0;
    while (!mem_ack_i && g < 40) begin
      cyc();
      neg();
      n_alloc++;
      g++;
    end
    chk("cm_ack_seen", mem_ack_i, 1'b1);
    chk("cm_alloc_cycles", n_alloc, 10);
    chk("cm_fill_tag", tag_data_o, 24'h800002);
    chk("cm_fill_writes", {tag_write_o, data_write_o}, 2'b11);
    cyc();
    neg();
    chk("cm_refill_done", {p1.p1_stall_o, mem_enable_o, data_write_o, tag_write_o}, 4'b1000);
    cyc();
    neg();
    chk("cm_retry_stall", p1.p1_stall_o, 1'b0);
    chk("cm_retry_data", p1.p1_data_o, 32'hA5A5_0800);

    // Dirty miss on line 3, latency 3.
    mem_lat = 3;
    exp_line = line3;
    exp_line[31:0]  = 32'h1234_5678;
    exp_line[63:32] = 32'hCAFE_F00D;
    cyc();
    drive(1'b1, 1'b0, 32'h0000_0C60, 32'h0);
    neg();
    chk("dm_idle_stall", p1.p1_stall_o, 1'b1);
    cyc();
    neg();
    chk("dm_miss_mem", mem_enable_o, 1'b0);
    cyc();
    neg();
    chk("dm_wb_en", {mem_enable_o, mem_write_o}, 2'b11);
    chk("dm_wb_addr", mem_addr_o, 32'h0000_0460);
    chk("dm_wb_data", mem_data_o, exp_line);
    g = 0;
    while (!mem_ack_i && g < 40) begin
      cyc();
      neg();
      g++;
    end
    chk("dm_wb_ack_seen", mem_ack_i, 1'b1);
    cyc();
    neg();
    chk("dm_alloc_en", {mem_enable_o, mem_write_o}, 2'b10);
    chk("dm_alloc_addr", mem_addr_o, 32'h0000_0C60);
    g = 0;
    while (p1.p1_stall_o && g < 40) begin
      cyc();
      neg();
      g++;
    end
    chk("dm_done", p1.p1_stall_o, 1'b0);
    chk("dm_retry_data", p1.p1_data_o, 32'hA5A5_0C60);

    // Dirty line 0, then reset during its writeback; a late ack is ignored.
    cyc();
    drive(1'b0, 1'b1, 32'h0000_0804, 32'h0BAD_F00D);
    neg();
    chk("rw_store", data_write_o, 1'b1);
    ack_en = 1'b0;
    cyc();
    drive(1'b1, 1'b0, 32'h0000_1800, 32'h0);
    neg();
    g = 0;
    while (!mem_write_o && g < 10) begin
      cyc();
      neg();
      g++;
    end
    chk("rw_in_writeback", mem_write_o, 1'b1);
    cyc();
    rst_i  = 1'b0;
    chk_en = 1'b0;
    neg();
    chk("rw_rst_mem", {mem_enable_o, mem_write_o}, 2'b00);
    chk("rw_rst_writes", {tag_write_o, data_write_o}, 2'b00);
    chk("rw_rst_stall", p1.p1_stall_o, 1'b1);
    cyc();
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    stray_ack = 1'b1;
    chk_en = 1'b1;
    neg();
    chk("rw_idle_mem", mem_enable_o, 1'b0);
    chk("rw_idle_stall", p1.p1_stall_o, 1'b0);
    cyc();
    stray_ack = 1'b0;
    neg();
    chk("rw_after_ack_mem", mem_enable_o, 1'b0);
    cyc();
    drive(1'b1, 1'b0, 32'h0000_0804, 32'h0);
    neg();
    chk("rw_hit_stall", p1.p1_stall_o, 1'b0);
    chk("rw_hit_data", p1.p1_data_o, 32'h0BAD_F00D);
    ack_en = 1'b1;

    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
